// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with a byte FIFO behind three picorv32 native-bus registers.
// Data register pops the head byte; status reports FIFO state and sticky flags; divisor sets baud.
module uart_rx_fifo #(
  parameter int unsigned DEFAULT_DIV = 234,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0004
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        rx_irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic             rx_meta_q, rx_s_q;
  logic [2:0]       state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      cur_div_q, cur_div_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic             ovr_q, ovr_d, fe_q, fe_d;
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             pop_pend_q, pop_pend_d;
  logic [31:0]      div_q, div_d;
  logic             irq_q, irq_d;

  logic        push_c, frame_set_c, do_push_c, ovr_set_c, pop_c;
  logic        full_c, empty_c, hit_c, is_wr_c, clr_ovr_c, clr_fe_c;
  logic        sel_data_c, sel_stat_c, sel_div_c;
  logic [31:0] eff_div_c, status_c;

  assign eff_div_c = (div_q < 32'd2) ? 32'd2 : div_q;
  assign full_c    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_c   = (count_q == '0);
  assign status_c  = {16'b0, 8'(count_q), 4'b0, fe_q, ovr_q, full_c, !empty_c};

  // Receive FSM: counter counts down to the next sample point; cur_div frozen per frame
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_div_d   = cur_div_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d   = S_START;
          cur_div_d = eff_div_c;
          cnt_d     = eff_div_c >> 1;
        end
      end
      S_START: begin
        if (cnt_q == 32'd0) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
            cnt_d     = cur_div_q - 32'd1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 32'd0) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = cur_div_q - 32'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == 32'd0) begin
          if (rx_s_q) begin
            push_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_set_c = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus decode: register address phase, answer one cycle later
  always_comb begin
    sel_data_c = (mem_addr == BASE_ADDR);
    sel_stat_c = (mem_addr == BASE_ADDR + 32'd4);
    sel_div_c  = (mem_addr == BASE_ADDR + 32'd8);
    hit_c      = mem_valid && !ready_q && (sel_data_c || sel_stat_c || sel_div_c);
    is_wr_c    = |mem_wstrb;
    ready_d    = hit_c;
    rdata_d    = 32'd0;
    pop_pend_d = 1'b0;
    div_d      = div_q;
    clr_ovr_c  = 1'b0;
    clr_fe_c   = 1'b0;
    if (hit_c) begin
      if (sel_data_c) begin
        rdata_d    = empty_c ? 32'hFFFF_FFFF : {24'b0, fifo_mem_q[rd_ptr_q]};
        pop_pend_d = !is_wr_c && !empty_c;
      end else if (sel_stat_c) begin
        rdata_d   = status_c;
        clr_ovr_c = mem_wstrb[0] && mem_wdata[2];
        clr_fe_c  = mem_wstrb[0] && mem_wdata[3];
      end else begin
        rdata_d = div_q;
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b]) div_d[8*b +: 8] = mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // FIFO bookkeeping; a pop is only ever pending against a non-empty FIFO
  always_comb begin
    pop_c     = ready_q && pop_pend_q;
    do_push_c = push_c && (!full_c || pop_c);
    ovr_set_c = push_c && full_c && !pop_c;
    wr_ptr_d  = do_push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    if (do_push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (!do_push_c && pop_c) count_d = count_q - CNT_W'(1);
    ovr_d = (ovr_q && !clr_ovr_c) || ovr_set_c;
    fe_d  = (fe_q && !clr_fe_c) || frame_set_c;
    irq_d = !empty_c;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= 32'd0;
      cur_div_q  <= 32'(DEFAULT_DIV);
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
      pop_pend_q <= 1'b0;
      div_q      <= 32'(DEFAULT_DIV);
      irq_q      <= 1'b0;
    end else begin
      rx_meta_q  <= ser_rx;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      pop_pend_q <= pop_pend_d;
      div_q      <= div_d;
      irq_q      <= irq_d;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push_c) fifo_mem_q[wr_ptr_q] <= shift_q;
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign rx_irq    = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo; a byte queue models the FIFO and supplies expected reads.
module tb_uart_rx_fifo;

  localparam logic [31:0] A_DATA = 32'h1000_0004;
  localparam logic [31:0] A_STAT = 32'h1000_0008;
  localparam logic [31:0] A_DIV  = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ser_rx;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        rx_irq;

  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] exp_q[$];
  bit   ovr_m = 1'b0;
  bit   fe_m  = 1'b0;

  uart_rx_fifo dut (
    .clk(clk), .resetn(resetn), .ser_rx(ser_rx),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int n = exp_q.size();
    return {16'b0, 8'(n), 4'b0, fe_m, ovr_m, n == 16, n != 0};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus access; lat is the cycle count to mem_ready, -1 on timeout
  task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                     output logic [31:0] rdata, output int lat);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = addr; mem_wstrb = strb; mem_wdata = wdata;
    lat = -1; rdata = 32'hDEAD_BEEF;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        lat = i; rdata = mem_rdata;
        break;
      end
    end
    @(negedge clk);
    mem_valid = 1'b0; mem_wstrb = 4'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d; int lat;
    bus(addr, 4'b0, 32'd0, d, lat);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check(tag, d, exp);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                    input logic [31:0] data);
    logic [31:0] d; int lat;
    bus(addr, strb, data, d, lat);
    check({tag, "_lat"}, 32'(lat), 32'd1);
  endtask

  // Data read: expected value popped from the scoreboard
  task automatic rd_data(input string tag);
    logic [31:0] exp;
    exp = (exp_q.size() != 0) ? {24'b0, exp_q.pop_front()} : 32'hFFFF_FFFF;
    rd(tag, A_DATA, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int div, input bit stop);
    if (!stop)                 fe_m = 1'b1;
    else if (exp_q.size() < 16) exp_q.push_back(b);
    else                       ovr_m = 1'b1;
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (div) @(negedge clk);
    end
    ser_rx = stop;
    repeat (div) @(negedge clk);
    if (stop) repeat (div / 2 + 4) @(negedge clk);
  endtask

  initial begin
    bit seen;
    resetn = 1'b0; ser_rx = 1'b1; mem_valid = 1'b0;
    mem_addr = 32'd0; mem_wstrb = 4'b0; mem_wdata = 32'd0;
    wait_cycles(3);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_irq", 32'(rx_irq), 32'd0);
    @(negedge clk); resetn = 1'b1;
    wait_cycles(2);

    // Reset register values and single-cycle ready pulse
    rd_data("t1_data_empty");
    @(posedge clk); #1;
    check("t1_ready_pulse", 32'(mem_ready), 32'd0);
    rd("t1_status", A_STAT, 32'h0000_0000);
    rd("t1_div", A_DIV, 32'd234);

    // Addresses outside the block are never acknowledged
    @(negedge clk); mem_valid = 1'b1; mem_addr = 32'h1000_0000; seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; seen |= mem_ready; end
    @(negedge clk); mem_addr = 32'h1000_0010;
    repeat (4) begin @(posedge clk); #1; seen |= mem_ready; end
    @(negedge clk); mem_valid = 1'b0;
    check("oob_ready", 32'(seen), 32'd0);

    // Byte-strobed divisor write, two bytes received
    wr("t2_div_wr", A_DIV, 4'b0001, 32'hFFFF_FF10);
    rd("t2_div", A_DIV, 32'd16);
    send_byte(8'h55, 16, 1'b1);
    send_byte(8'hA3, 16, 1'b1);
    check("t2_irq_set", 32'(rx_irq), 32'd1);
    rd("t2_status2", A_STAT, exp_status());
    rd_data("t2_data0");
    rd_data("t2_data1");
    wait_cycles(3);
    rd("t2_status0", A_STAT, exp_status());
    check("t2_irq_clr", 32'(rx_irq), 32'd0);

    // Short low glitch is a false start; next frame still decodes
    @(negedge clk); ser_rx = 1'b0;
    repeat (5) @(negedge clk);
    ser_rx = 1'b1;
    repeat (40) @(negedge clk);
    rd("t3_status", A_STAT, 32'h0000_0000);
    send_byte(8'h3C, 16, 1'b1);
    rd_data("t3_data");

    // Overrun: 17 bytes into a 16-entry FIFO
    for (int i = 0; i < 17; i++) send_byte(8'(i), 16, 1'b1);
    rd("t4_status_full", A_STAT, exp_status());
    for (int i = 0; i < 16; i++) rd_data($sformatf("t4_data%0d", i));
    wait_cycles(2);
    rd("t4_status_ovr", A_STAT, exp_status());
    wr("t4_clr_wr", A_STAT, 4'b0001, 32'h4);
    ovr_m = 1'b0;
    rd("t4_status_clr", A_STAT, exp_status());

    // Framing error followed by a line break, then recovery
    send_byte(8'h7E, 16, 1'b0);
    repeat (40) @(negedge clk);
    rd("t5_status_fe", A_STAT, exp_status());
    ser_rx = 1'b1;
    repeat (32) @(negedge clk);
    send_byte(8'h42, 16, 1'b1);
    rd("t5_status_rx", A_STAT, exp_status());
    rd_data("t5_data");
    wr("t5_clr_wr", A_STAT, 4'b0001, 32'h8);
    fe_m = 1'b0;
    rd("t5_status_clr", A_STAT, exp_status());

    // Divisor change mid-frame applies only from the next frame
    fork
      send_byte(8'h5A, 16, 1'b1);
      begin
        repeat (50) @(negedge clk);
        wr("t6_div_wr", A_DIV, 4'b1111, 32'd8);
      end
    join
    send_byte(8'hC3, 8, 1'b1);
    rd("t6_div", A_DIV, 32'd8);
    rd("t6_status", A_STAT, exp_status());
    rd_data("t6_data_old");
    rd_data("t6_data_new");
    rd_data("t6_data_empty");

    wait_cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
